mem_port_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch requester (IF) and the data-memory requester (DM/MEM stage).
- The memory has combinational read and a write that commits on the clock edge while mem_we is high.
- The arbiter serialises accesses and inserts WAIT_STATES extra cycles per access to model slow memory.
- It returns per-requester acks; the pipeline uses the absence of an ack as its stall condition.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch requester (IF) and the data requester (DM). Accesses are serialised,
// each lasting WAIT_STATES+1 cycles, and contention alternates between the
// two requesters. Optional grant/conflict statistics are compiled in when the
// macro MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_ack,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]           stat_if_grants,
   output logic [15:0]           stat_dm_grants,
   output logic [15:0]           stat_conflicts
`endif
);

   localparam logic [3:0] WS = WAIT_STATES[3:0];

   typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  last_dm, last_dm_nxt;   // 1 = last grant went to DM
   logic                  we_q, we_nxt;           // captured dm_we of the current access
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt;
   logic                  ack_cycle, decide, grant_if, grant_dm, conflict;

   // Register state, counter, grant history and the captured access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         last_dm   <= 1'b0;
         we_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last_dm   <= last_dm_nxt;
         we_q      <= we_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
      end
   end

   // Decision logic: the ack cycle doubles as a decision point so that
   // back-to-back accesses run without an idle bubble.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      last_dm_nxt = last_dm;
      we_nxt      = we_q;
      addr_nxt    = mem_addr;
      wdata_nxt   = mem_wdata;

      ack_cycle = (state != IDLE) && (cnt == 4'd0);
      decide    = (state == IDLE) || ack_cycle;
      conflict  = decide && if_req && dm_req;
      grant_dm  = decide && dm_req && (!if_req || !last_dm);
      grant_if  = decide && if_req && (!dm_req || last_dm);

      if ((state != IDLE) && (cnt != 4'd0))
         cnt_nxt = cnt - 4'd1;

      if (decide)
         state_nxt = IDLE;

      if (grant_dm) begin
         state_nxt   = ACC_DM;
         cnt_nxt     = WS;
         last_dm_nxt = 1'b1;
         we_nxt      = dm_we;
         addr_nxt    = dm_addr;
         wdata_nxt   = dm_wdata;
      end else if (grant_if) begin
         state_nxt   = ACC_IF;
         cnt_nxt     = WS;
         last_dm_nxt = 1'b0;
         we_nxt      = 1'b0;
         addr_nxt    = if_addr;
      end
   end

   // Acks, write strobe and read-data steering are valid only in the ack cycle.
   always_comb begin
      if_ack   = ack_cycle && (state == ACC_IF);
      dm_ack   = ack_cycle && (state == ACC_DM);
      mem_we   = dm_ack && we_q;
      busy     = (state != IDLE);
      if_rdata = if_ack ? mem_rdata : '0;
      dm_rdata = dm_ack ? mem_rdata : '0;
   end

`ifdef MEM_ARB_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating grant and conflict counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_if_grants <= 16'd0;
         stat_dm_grants <= 16'd0;
         stat_conflicts <= 16'd0;
      end else begin
         if (grant_if) stat_if_grants <= sat_inc(stat_if_grants);
         if (grant_dm) stat_dm_grants <= sat_inc(stat_dm_grants);
         if (conflict) stat_conflicts <= sat_inc(stat_conflicts);
      end
   end
`endif

endmodule
